// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
// start/busy/done handshake; results held until the next accepted start.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d_q, d_d;      // latched divisor
  logic [WIDTH:0]   r_q, r_d;      // partial remainder accumulator
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic [WIDTH:0]   r_nx;
  logic [WIDTH-1:0] q_nx;

  // Trial subtraction: R' + ~{0,D} + 1; the carry out of bit WIDTH means R' >= D.
  always_comb begin
    r_sh      = (r_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
    trial     = {1'b0, r_sh} + {1'b0, ~{1'b0, d_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    no_borrow = trial[WIDTH+1];
    r_nx      = no_borrow ? trial[WIDTH:0] : r_sh;
    q_nx      = {q_q[WIDTH-2:0], no_borrow};
  end

  // Control FSM and datapath next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          dbz_d   = 1'b0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (d_q == '0) begin
          // Zero divisor: resolved in the single busy cycle, no iterations.
          quot_d  = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          r_d = r_nx;
          q_d = q_nx;
          if (cnt_q == '0) begin
            quot_d  = q_nx;
            rem_d   = r_nx[WIDTH-1:0];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, cleared asynchronously (aborts any operation in flight).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
